// File: rtl/hdp_axil_slave_if.sv
// AXI4-Lite bundle between the S00_AXI interconnect port (master) and the HamDistPop register slave.
interface hdp_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/hdp_axil_slave.sv
// AXI4-Lite register front end with an iterative Hamming-distance / popcount engine (CHUNK bits per cycle).
// Optional macro HDP_IRQ_EN adds the irq output and the CTRL.IRQ_EN bit.
module hdp_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CHUNK              = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
`ifdef HDP_IRQ_EN
  output logic irq,
`endif
  hdp_axil_slave_if.slave s_axi
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int N_RUN = 32 / CHUNK;
  localparam logic [5:0] LAST_CNT = 6'(N_RUN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] IDX_OPA  = 2'd0;
  localparam logic [1:0] IDX_OPB  = 2'd1;
  localparam logic [1:0] IDX_CTRL = 2'd2;
  localparam logic [1:0] IDX_RES  = 2'd3;

  localparam int B_MODE  = 0;
  localparam int B_START = 1;
  localparam int B_BUSY  = 2;
  localparam int B_DONE  = 3;
  localparam int B_OVR   = 4;
`ifdef HDP_IRQ_EN
  localparam int B_IRQEN = 5;
`endif

  function automatic logic [5:0] f_popcount(input logic [CHUNK-1:0] v);
    logic [5:0] sum;
    sum = 6'd0;
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + {5'd0, v[i]};
    end
    return sum;
  endfunction

  function automatic logic [DW-1:0] f_strb_merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Bus-side aliases
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_araddr;
  logic [DW-1:0]                 w_wdata;
  logic [SW-1:0]                 w_wstrb;
  logic [1:0]                    w_wr_idx;
  logic [1:0]                    w_rd_idx;
  logic                          w_unused_ok;

  assign w_awaddr = s_axi.S_AXI_AWADDR;
  assign w_araddr = s_axi.S_AXI_ARADDR;
  assign w_wdata  = s_axi.S_AXI_WDATA;
  assign w_wstrb  = s_axi.S_AXI_WSTRB;
  assign w_wr_idx = w_awaddr[3:2];
  assign w_rd_idx = w_araddr[3:2];
  assign w_unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, w_awaddr[1:0], w_araddr[1:0]};

  // Channel state
  logic          r_awready;
  logic          r_bvalid;
  logic          r_arready;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  // Register file and engine state
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic          r_mode;
  logic          r_done;
  logic          r_ovr;
  logic [5:0]    r_result;
  logic [1:0]    r_state;
  logic [31:0]   r_x;
  logic [5:0]    r_acc;
  logic [5:0]    r_cnt;
`ifdef HDP_IRQ_EN
  logic          r_irq_en;
  logic          r_irq;
`endif

  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_ctrl_b0;
  logic          w_start;
  logic          w_busy;
  logic          w_launch;
  logic          w_ovr_set;
  logic          w_done_set;
  logic [31:0]   w_x_init;
  logic [DW-1:0] w_ctrl_rd;
  logic [DW-1:0] w_rdata_mux;

  // A write handshake completes on the edge where the one-cycle ready pulse meets both valids.
  assign w_wr_en    = r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign w_rd_en    = r_arready & s_axi.S_AXI_ARVALID;
  assign w_ctrl_b0  = w_wr_en & (w_wr_idx == IDX_CTRL) & w_wstrb[0];
  assign w_start    = w_ctrl_b0 & w_wdata[B_START];
  assign w_busy     = (r_state != S_IDLE);
  assign w_launch   = w_start & ~w_busy;
  assign w_ovr_set  = w_start & w_busy;
  assign w_done_set = (r_state == S_DONE);
  // MODE used for the snapshot is the value being written in the same beat as START.
  assign w_x_init   = w_wdata[B_MODE] ? (r_opa ^ r_opb) : r_opa;

  always_comb begin
    w_ctrl_rd         = '0;
    w_ctrl_rd[B_MODE] = r_mode;
    w_ctrl_rd[B_BUSY] = w_busy;
    w_ctrl_rd[B_DONE] = r_done;
    w_ctrl_rd[B_OVR]  = r_ovr;
`ifdef HDP_IRQ_EN
    w_ctrl_rd[B_IRQEN] = r_irq_en;
`endif
  end

  always_comb begin
    w_rdata_mux = '0;
    case (w_rd_idx)
      IDX_OPA:  w_rdata_mux = r_opa;
      IDX_OPB:  w_rdata_mux = r_opb;
      IDX_CTRL: w_rdata_mux = w_ctrl_rd;
      IDX_RES:  w_rdata_mux = {{(DW-6){1'b0}}, r_result};
      default:  w_rdata_mux = '0;
    endcase
  end

  // Write address/data acceptance and response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_en)
        r_bvalid <= 1'b1;
      else if (s_axi.S_AXI_BREADY)
        r_bvalid <= 1'b0;
    end
  end

  // Read address acceptance and registered read data
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_mux;
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Software-visible registers; DONE and OVR sets take priority over W1C
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_mode <= 1'b0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef HDP_IRQ_EN
      r_irq_en <= 1'b0;
`endif
    end else begin
      if (w_wr_en && w_wr_idx == IDX_OPA) r_opa <= f_strb_merge(r_opa, w_wdata, w_wstrb);
      if (w_wr_en && w_wr_idx == IDX_OPB) r_opb <= f_strb_merge(r_opb, w_wdata, w_wstrb);
      if (w_ctrl_b0) r_mode <= w_wdata[B_MODE];
`ifdef HDP_IRQ_EN
      if (w_ctrl_b0) r_irq_en <= w_wdata[B_IRQEN];
`endif
      if (w_done_set)
        r_done <= 1'b1;
      else if (w_ctrl_b0 && w_wdata[B_DONE])
        r_done <= 1'b0;
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_ctrl_b0 && w_wdata[B_OVR])
        r_ovr <= 1'b0;
    end
  end

  // Engine: IDLE -> RUN for N_RUN chunks -> DONE (publish result) -> IDLE
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_RUN;
            r_x     <= w_x_init;
            r_acc   <= 6'd0;
            r_cnt   <= 6'd0;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + f_popcount(r_x[CHUNK-1:0]);
          r_x   <= r_x >> CHUNK;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_CNT) r_state <= S_DONE;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef HDP_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      r_irq <= 1'b0;
    else
      r_irq <= r_done & r_irq_en;
  end

  assign irq = r_irq;
`endif

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_awready;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = r_rvalid;

endmodule
